// File: rtl/fmpadding_cfg.sv
// fmpadding_cfg
// Double-buffered configuration bank for the feature-map padding datapath.
// Software writes six padding bounds into shadow registers, then writes a
// COMMIT word. The shadow copy is transferred to the active copy only when a
// commit is armed and the datapath is at a frame boundary (sof) or idle, so a
// frame in flight never observes a partially updated configuration.
//
// Ports:
//   ap_clk      clock
//   ap_rst_n    asynchronous active-low reset (release synchronous to ap_clk)
//   we/wa/wd    single-cycle write strobe, byte address, 32-bit write data
//   sof         one-cycle pulse: datapath starts a new frame this cycle
//   idle        level: datapath has no frame in flight
//   xon/xoff/xend, yon/yoff/yend   active padding bounds
//   pending     a commit is armed but not yet applied
//   applied     one-cycle pulse coincident with the active update
//   commit_cnt  number of applied commits, modulo 256
//
// Word map (index = wa[ADDR_BITS-1:2]):
//   0 XOn, 1 XOff, 2 XEnd, 3 YOn, 4 YOff, 5 YEnd, 6 COMMIT, 7+ dropped.

module fmpadding_cfg #(
  parameter int ADDR_BITS     = 5,
  parameter int XCOUNTER_BITS = 8,
  parameter int YCOUNTER_BITS = 8,
  parameter int INIT_XON      = 0,
  parameter int INIT_XOFF     = 0,
  parameter int INIT_XEND     = 0,
  parameter int INIT_YON      = 0,
  parameter int INIT_YOFF     = 0,
  parameter int INIT_YEND     = 0
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     we,
  input  logic [ADDR_BITS-1:0]     wa,
  input  logic [31:0]              wd,
  input  logic                     sof,
  input  logic                     idle,
  output logic [XCOUNTER_BITS-1:0] xon,
  output logic [XCOUNTER_BITS-1:0] xoff,
  output logic [XCOUNTER_BITS-1:0] xend,
  output logic [YCOUNTER_BITS-1:0] yon,
  output logic [YCOUNTER_BITS-1:0] yoff,
  output logic [YCOUNTER_BITS-1:0] yend,
  output logic                     pending,
  output logic                     applied,
  output logic [7:0]               commit_cnt
);

  localparam int IDX_BITS = ADDR_BITS - 2;
  localparam int XW       = XCOUNTER_BITS;
  localparam int YW       = YCOUNTER_BITS;

  function automatic logic [XW-1:0] init_x(input int i);
    if (i == 0)      return XW'(INIT_XON);
    else if (i == 1) return XW'(INIT_XOFF);
    else             return XW'(INIT_XEND);
  endfunction

  function automatic logic [YW-1:0] init_y(input int i);
    if (i == 0)      return YW'(INIT_YON);
    else if (i == 1) return YW'(INIT_YOFF);
    else             return YW'(INIT_YEND);
  endfunction

  logic [IDX_BITS-1:0] word_idx;
  logic                commit_wr;
  logic                apply;
  logic                pending_reg;
  logic                applied_reg;
  logic [7:0]          commit_cnt_reg;

  assign word_idx  = wa[ADDR_BITS-1:2];
  assign commit_wr = we && (word_idx == IDX_BITS'(6));
  // Uses the registered pending, so a commit written this cycle can apply
  // no earlier than the next cycle.
  assign apply     = pending_reg && (sof || idle);

  // X bounds: word indices 0..2. The active copy samples the shadow value
  // from before this cycle's write, so a write racing an apply stays in
  // shadow until the next commit.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_x
      logic [XW-1:0] shadow_reg;
      logic [XW-1:0] active_reg;
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          shadow_reg <= init_x(gi);
          active_reg <= init_x(gi);
        end else begin
          if (we && (word_idx == IDX_BITS'(gi)))
            shadow_reg <= wd[XW-1:0];
          if (apply)
            active_reg <= shadow_reg;
        end
      end
    end

    // Y bounds: word indices 3..5.
    for (gi = 0; gi < 3; gi++) begin : g_y
      logic [YW-1:0] shadow_reg;
      logic [YW-1:0] active_reg;
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          shadow_reg <= init_y(gi);
          active_reg <= init_y(gi);
        end else begin
          if (we && (word_idx == IDX_BITS'(gi + 3)))
            shadow_reg <= wd[YW-1:0];
          if (apply)
            active_reg <= shadow_reg;
        end
      end
    end
  endgenerate

  // Commit tracking. A commit arriving in the same cycle as an apply
  // re-arms pending, so the second commit is not lost.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pending_reg    <= 1'b0;
      applied_reg    <= 1'b0;
      commit_cnt_reg <= 8'd0;
    end else begin
      if (commit_wr)
        pending_reg <= 1'b1;
      else if (apply)
        pending_reg <= 1'b0;
      applied_reg <= apply;
      if (apply)
        commit_cnt_reg <= commit_cnt_reg + 8'd1;
    end
  end

  assign xon        = g_x[0].active_reg;
  assign xoff       = g_x[1].active_reg;
  assign xend       = g_x[2].active_reg;
  assign yon        = g_y[0].active_reg;
  assign yoff       = g_y[1].active_reg;
  assign yend       = g_y[2].active_reg;
  assign pending    = pending_reg;
  assign applied    = applied_reg;
  assign commit_cnt = commit_cnt_reg;

endmodule

// File: tb/tb_fmpadding_cfg.sv
// Testbench for fmpadding_cfg: table of {inputs, expected outputs} records
// pushed to a scoreboard queue when driven, popped and compared one clock
// later; plus hand-written counter-wrap and asynchronous-reset sequences.

module tb_fmpadding_cfg;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sof;
    logic        idle;
    logic [7:0]  xon, xoff, xend, yon, yoff, yend;
    logic        pend;
    logic        app;
    logic [7:0]  cnt;
  } vec_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        sof = 1'b0;
  logic        idle = 1'b0;
  logic [7:0]  xon, xoff, xend, yon, yoff, yend;
  logic        pending, applied;
  logic [7:0]  commit_cnt;

  int checks = 0;
  int failures = 0;
  vec_t exp_q[$];
  vec_t tbl[25];

  fmpadding_cfg dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .we(we), .wa(wa), .wd(wd), .sof(sof), .idle(idle),
    .xon(xon), .xoff(xoff), .xend(xend),
    .yon(yon), .yoff(yoff), .yend(yend),
    .pending(pending), .applied(applied), .commit_cnt(commit_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic vec_t mk(input logic we_i, input logic [4:0] wa_i,
                              input logic [31:0] wd_i, input logic sof_i,
                              input logic idle_i, input logic [7:0] x0,
                              input logic [7:0] x1, input logic [7:0] x2,
                              input logic [7:0] y0, input logic [7:0] y1,
                              input logic [7:0] y2, input logic p,
                              input logic a, input logic [7:0] c);
    vec_t v;
    v.we = we_i; v.wa = wa_i; v.wd = wd_i; v.sof = sof_i; v.idle = idle_i;
    v.xon = x0; v.xoff = x1; v.xend = x2;
    v.yon = y0; v.yoff = y1; v.yend = y2;
    v.pend = p; v.app = a; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compare_all(input string tag, input vec_t e);
    chk({tag, ".xon"},  32'(xon),  32'(e.xon));
    chk({tag, ".xoff"}, 32'(xoff), 32'(e.xoff));
    chk({tag, ".xend"}, 32'(xend), 32'(e.xend));
    chk({tag, ".yon"},  32'(yon),  32'(e.yon));
    chk({tag, ".yoff"}, 32'(yoff), 32'(e.yoff));
    chk({tag, ".yend"}, 32'(yend), 32'(e.yend));
    chk({tag, ".pending"},    32'(pending),    32'(e.pend));
    chk({tag, ".applied"},    32'(applied),    32'(e.app));
    chk({tag, ".commit_cnt"}, 32'(commit_cnt), 32'(e.cnt));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic run_vec(input string tag, input vec_t v);
    vec_t e;
    @(negedge ap_clk);
    we = v.we; wa = v.wa; wd = v.wd; sof = v.sof; idle = v.idle;
    exp_q.push_back(v);
    @(posedge ap_clk);
    #1;
    e = exp_q.pop_front();
    compare_all(tag, e);
    $display("%s we=%0b wa=%0h wd=%0h sof=%0b idle=%0b -> x=%0h/%0h/%0h y=%0h/%0h/%0h pend=%0b app=%0b cnt=%0d",
             tag, v.we, v.wa, v.wd, v.sof, v.idle, xon, xoff, xend,
             yon, yoff, yend, pending, applied, commit_cnt);
  endtask

  initial begin
    vec_t cur;
    vec_t zero;

    // Buffered apply
    tbl[0]  = mk(1, 5'h00, 32'h3,    0, 0, 8'h0, 8'h0,  8'h0, 8'h0,  8'h0,  8'h0, 0, 0, 8'd0);
    tbl[1]  = mk(1, 5'h14, 32'h9,    0, 0, 8'h0, 8'h0,  8'h0, 8'h0,  8'h0,  8'h0, 0, 0, 8'd0);
    tbl[2]  = mk(1, 5'h18, 32'hDEAD, 0, 0, 8'h0, 8'h0,  8'h0, 8'h0,  8'h0,  8'h0, 1, 0, 8'd0);
    tbl[3]  = mk(0, 5'h00, 32'h0,    0, 0, 8'h0, 8'h0,  8'h0, 8'h0,  8'h0,  8'h0, 1, 0, 8'd0);
    tbl[4]  = mk(0, 5'h00, 32'h0,    1, 0, 8'h3, 8'h0,  8'h0, 8'h0,  8'h0,  8'h9, 0, 1, 8'd1);
    tbl[5]  = mk(0, 5'h00, 32'h0,    0, 0, 8'h3, 8'h0,  8'h0, 8'h0,  8'h0,  8'h9, 0, 0, 8'd1);
    // Idle apply with truncation
    tbl[6]  = mk(1, 5'h04, 32'h1FF,  0, 1, 8'h3, 8'h0,  8'h0, 8'h0,  8'h0,  8'h9, 0, 0, 8'd1);
    tbl[7]  = mk(1, 5'h18, 32'h0,    0, 1, 8'h3, 8'h0,  8'h0, 8'h0,  8'h0,  8'h9, 1, 0, 8'd1);
    tbl[8]  = mk(0, 5'h00, 32'h0,    0, 1, 8'h3, 8'hFF, 8'h0, 8'h0,  8'h0,  8'h9, 0, 1, 8'd2);
    tbl[9]  = mk(0, 5'h00, 32'h0,    0, 1, 8'h3, 8'hFF, 8'h0, 8'h0,  8'h0,  8'h9, 0, 0, 8'd2);
    // Shadow write racing an apply: active gets the old XEnd
    tbl[10] = mk(1, 5'h18, 32'h0,    0, 0, 8'h3, 8'hFF, 8'h0, 8'h0,  8'h0,  8'h9, 1, 0, 8'd2);
    tbl[11] = mk(1, 5'h08, 32'h7,    1, 0, 8'h3, 8'hFF, 8'h0, 8'h0,  8'h0,  8'h9, 0, 1, 8'd3);
    tbl[12] = mk(0, 5'h00, 32'h0,    1, 0, 8'h3, 8'hFF, 8'h0, 8'h0,  8'h0,  8'h9, 0, 0, 8'd3);
    tbl[13] = mk(1, 5'h18, 32'h0,    0, 0, 8'h3, 8'hFF, 8'h0, 8'h0,  8'h0,  8'h9, 1, 0, 8'd3);
    tbl[14] = mk(0, 5'h00, 32'h0,    1, 0, 8'h3, 8'hFF, 8'h7, 8'h0,  8'h0,  8'h9, 0, 1, 8'd4);
    // COMMIT racing an apply: pending stays armed
    tbl[15] = mk(1, 5'h18, 32'h0,    0, 0, 8'h3, 8'hFF, 8'h7, 8'h0,  8'h0,  8'h9, 1, 0, 8'd4);
    tbl[16] = mk(1, 5'h18, 32'h0,    1, 0, 8'h3, 8'hFF, 8'h7, 8'h0,  8'h0,  8'h9, 1, 1, 8'd5);
    tbl[17] = mk(0, 5'h00, 32'h0,    0, 0, 8'h3, 8'hFF, 8'h7, 8'h0,  8'h0,  8'h9, 1, 0, 8'd5);
    tbl[18] = mk(0, 5'h00, 32'h0,    0, 1, 8'h3, 8'hFF, 8'h7, 8'h0,  8'h0,  8'h9, 0, 1, 8'd6);
    // Ignored address, then Y writes with truncation
    tbl[19] = mk(1, 5'h1C, 32'hFFFFFFFF, 0, 0, 8'h3, 8'hFF, 8'h7, 8'h0, 8'h0, 8'h9, 0, 0, 8'd6);
    tbl[20] = mk(1, 5'h1C, 32'hFFFFFFFF, 1, 0, 8'h3, 8'hFF, 8'h7, 8'h0, 8'h0, 8'h9, 0, 0, 8'd6);
    tbl[21] = mk(1, 5'h0C, 32'h121,  0, 0, 8'h3, 8'hFF, 8'h7, 8'h0,  8'h0,  8'h9, 0, 0, 8'd6);
    tbl[22] = mk(1, 5'h10, 32'h42,   0, 0, 8'h3, 8'hFF, 8'h7, 8'h0,  8'h0,  8'h9, 0, 0, 8'd6);
    tbl[23] = mk(1, 5'h18, 32'h0,    0, 0, 8'h3, 8'hFF, 8'h7, 8'h0,  8'h0,  8'h9, 1, 0, 8'd6);
    tbl[24] = mk(0, 5'h00, 32'h0,    1, 0, 8'h3, 8'hFF, 8'h7, 8'h21, 8'h42, 8'h9, 0, 1, 8'd7);

    zero = mk(0, 5'h00, 32'h0, 0, 0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 0, 0, 8'd0);

    // Reset state, checked while reset is held and after a couple of edges
    #2;
    compare_all("reset_hold", zero);
    repeat (2) @(posedge ap_clk);
    #1;
    compare_all("reset_edges", zero);
    $display("reset_check done");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    for (int i = 0; i < 25; i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // Counter wrap: 249 more commit/sof pairs take the count from 7 to 0
    cur = tbl[24];
    for (int i = 0; i < 249; i++) begin
      cur.we = 1; cur.wa = 5'h18; cur.wd = 32'h0; cur.sof = 0; cur.idle = 0;
      cur.pend = 1; cur.app = 0;
      run_vec($sformatf("wrap_commit%0d", i), cur);
      cur.we = 0; cur.wa = 5'h00; cur.sof = 1;
      cur.pend = 0; cur.app = 1; cur.cnt = cur.cnt + 8'd1;
      run_vec($sformatf("wrap_sof%0d", i), cur);
    end
    chk("wrap_final_cnt", 32'(commit_cnt), 32'd0);

    // Async reset mid-frame with a commit armed
    cur.we = 1; cur.wa = 5'h18; cur.sof = 0; cur.idle = 0;
    cur.pend = 1; cur.app = 0;
    run_vec("arm_before_reset", cur);
    @(negedge ap_clk);
    we = 0; sof = 0; idle = 0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    compare_all("async_reset", zero);
    $display("async_reset asserted between edges pend=%0b cnt=%0d xon=%0h",
             pending, commit_cnt, xon);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    // Idle after release: the armed commit must be gone
    cur = zero;
    cur.idle = 1;
    run_vec("post_reset_idle", cur);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
